// File: rtl/life_array_param.sv
// ROWS x COLS B3/S23 Game-of-Life array: row load/readback, previous-generation snapshot, edge ports, optional torus wrap.
// Write or step takes effect on the next clk edge (1 clock latency); no backpressure, a command is accepted every cycle.
module life_array_param #(
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int SEL_W = $clog2(ROWS),
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [COLS-1:0]  vali,
   input  logic [SEL_W-1:0] vali_selector,
   input  logic             write_enb,
   input  logic [SEL_W-1:0] valo_selector,
   output logic [COLS-1:0]  valo,
   output logic [COLS-1:0]  valo_prev,
   input  logic             step,
   input  logic             wrap_mode,
   input  logic [COLS-1:0]  ni,
   input  logic [COLS-1:0]  si,
   input  logic [ROWS-1:0]  wi,
   input  logic [ROWS-1:0]  ei,
   input  logic             nwi,
   input  logic             nei,
   input  logic             sei,
   input  logic             swi,
   output logic [COLS-1:0]  no,
   output logic [COLS-1:0]  so,
   output logic [ROWS-1:0]  wo,
   output logic [ROWS-1:0]  eo,
   output logic             nwo,
   output logic             neo,
   output logic             seo,
   output logic             swo,
   output logic [GEN_W-1:0] generation,
   output logic             stable
);

   logic [ROWS-1:0][COLS-1:0] cur;
   logic [ROWS-1:0][COLS-1:0] prev;
   logic [ROWS-1:0][COLS-1:0] nxt;

   // Array surrounded by a one-cell halo, so every cell sees the same 3x3 window.
   logic [ROWS+1:0][COLS+1:0] pad;

   always_comb begin : halo
      pad = '0;
      for (int r = 0; r < ROWS; r++) begin
         pad[r+1][COLS:1] = cur[r];
         pad[r+1][0]      = wrap_mode ? cur[r][COLS-1] : wi[r];
         pad[r+1][COLS+1] = wrap_mode ? cur[r][0]      : ei[r];
      end
      pad[0][COLS:1]      = wrap_mode ? cur[ROWS-1]         : ni;
      pad[ROWS+1][COLS:1] = wrap_mode ? cur[0]              : si;
      pad[0][0]           = wrap_mode ? cur[ROWS-1][COLS-1] : nwi;
      pad[0][COLS+1]      = wrap_mode ? cur[ROWS-1][0]      : nei;
      pad[ROWS+1][COLS+1] = wrap_mode ? cur[0][0]           : sei;
      pad[ROWS+1][0]      = wrap_mode ? cur[0][COLS-1]      : swi;
   end

   always_comb begin : rule
      logic [3:0] cnt;
      cnt = '0;
      nxt = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            cnt = '0;
            for (int dr = 0; dr < 3; dr++) begin
               for (int dc = 0; dc < 3; dc++) begin
                  if (dr != 1 || dc != 1) begin
                     cnt = cnt + 4'(pad[r+dr][c+dc]);
                  end
               end
            end
            nxt[r][c] = (cnt == 4'd3) || (pad[r+1][c+1] && (cnt == 4'd2));
         end
      end
   end

   // Selector compare per row: out-of-range selectors match nothing and read as 0.
   always_comb begin : readback
      valo      = '0;
      valo_prev = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (valo_selector == SEL_W'(r)) begin
            valo      = cur[r];
            valo_prev = prev[r];
         end
      end
   end

   always_comb begin : edges
      wo = '0;
      eo = '0;
      for (int r = 0; r < ROWS; r++) begin
         wo[r] = cur[r][0];
         eo[r] = cur[r][COLS-1];
      end
   end

   assign no  = cur[0];
   assign so  = cur[ROWS-1];
   assign nwo = cur[0][0];
   assign neo = cur[0][COLS-1];
   assign seo = cur[ROWS-1][COLS-1];
   assign swo = cur[ROWS-1][0];

   // A write in the same cycle as a step takes priority and suppresses the evolution.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur        <= '0;
         prev       <= '0;
         generation <= '0;
         stable     <= 1'b0;
      end else if (write_enb) begin
         for (int r = 0; r < ROWS; r++) begin
            if (vali_selector == SEL_W'(r)) begin
               cur[r] <= vali;
            end
         end
         stable <= 1'b0;
      end else if (step) begin
         prev       <= cur;
         cur        <= nxt;
         generation <= generation + GEN_W'(1);
         stable     <= (nxt == cur);
      end
   end

endmodule

// File: tb/tb_life_array_param.sv
`timescale 1ns/1ps
module tb_life_array_param;
   localparam int R = 16;
   localparam int C = 16;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic        reset = 1'b1;
   logic [15:0] vali = '0;
   logic [3:0]  vali_selector = '0;
   logic        write_enb = 1'b0;
   logic [3:0]  valo_selector = '0;
   logic [15:0] valo, valo_prev;
   logic        step = 1'b0;
   logic        wrap_mode = 1'b0;
   logic [15:0] ni = '0, si = '0, wi = '0, ei = '0;
   logic        nwi = 1'b0, nei = 1'b0, sei = 1'b0, swi = 1'b0;
   logic [15:0] no, so, wo, eo;
   logic        nwo, neo, seo, swo;
   logic [15:0] generation;
   logic        stable;

   // Small non-power-of-2 instance with a narrow generation counter
   logic [5:0] s_vali = '0;
   logic [2:0] s_vsel = '0, s_osel = '0;
   logic       s_we = 1'b0, s_step = 1'b0, s_wrap = 1'b0;
   logic [5:0] s_valo, s_valo_prev, s_no, s_so;
   logic [4:0] s_wo, s_eo;
   logic       s_nwo, s_neo, s_seo, s_swo, s_stable;
   logic [2:0] s_gen;
   logic [5:0] s_zc = '0;
   logic [4:0] s_zr = '0;
   logic       s_z = 1'b0;

   life_array_param #(.ROWS(16), .COLS(16), .SEL_W(4), .GEN_W(16)) dut (
      .clk(clk), .reset(reset), .vali(vali), .vali_selector(vali_selector),
      .write_enb(write_enb), .valo_selector(valo_selector), .valo(valo),
      .valo_prev(valo_prev), .step(step), .wrap_mode(wrap_mode),
      .ni(ni), .si(si), .wi(wi), .ei(ei), .nwi(nwi), .nei(nei), .sei(sei), .swi(swi),
      .no(no), .so(so), .wo(wo), .eo(eo), .nwo(nwo), .neo(neo), .seo(seo), .swo(swo),
      .generation(generation), .stable(stable));

   life_array_param #(.ROWS(5), .COLS(6), .SEL_W(3), .GEN_W(3)) dut_small (
      .clk(clk), .reset(reset), .vali(s_vali), .vali_selector(s_vsel),
      .write_enb(s_we), .valo_selector(s_osel), .valo(s_valo),
      .valo_prev(s_valo_prev), .step(s_step), .wrap_mode(s_wrap),
      .ni(s_zc), .si(s_zc), .wi(s_zr), .ei(s_zr), .nwi(s_z), .nei(s_z), .sei(s_z), .swi(s_z),
      .no(s_no), .so(s_so), .wo(s_wo), .eo(s_eo), .nwo(s_nwo), .neo(s_neo), .seo(s_seo), .swo(s_swo),
      .generation(s_gen), .stable(s_stable));

   int n_checks = 0;
   int n_pass = 0;

   // Reference model: plain 2-D grid with explicit out-of-range lookup
   logic [15:0] m_cur [16];
   logic [15:0] m_prev [16];
   int          m_gen;
   bit          m_stable;
   logic [15:0] dut_cur [16];
   logic [15:0] dut_prev [16];

   function automatic bit mval(int r, int c);
      if (r >= 0 && r < R && c >= 0 && c < C) return m_cur[r][c];
      if (wrap_mode) return m_cur[(r + R) % R][(c + C) % C];
      if (r < 0 && c < 0) return nwi;
      if (r < 0 && c >= C) return nei;
      if (r >= R && c >= C) return sei;
      if (r >= R && c < 0) return swi;
      if (r < 0) return ni[c];
      if (r >= R) return si[c];
      if (c < 0) return wi[r];
      return ei[r];
   endfunction

   task automatic model_reset();
      for (int r = 0; r < R; r++) begin
         m_cur[r]  = '0;
         m_prev[r] = '0;
      end
      m_gen = 0;
      m_stable = 1'b0;
   endtask

   task automatic model_step();
      logic [15:0] nx [16];
      int n;
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0) n += int'(mval(r + dr, c + dc));
            nx[r][c] = (n == 3) || (m_cur[r][c] && n == 2);
         end
      end
      m_stable = 1'b1;
      for (int r = 0; r < R; r++) if (nx[r] != m_cur[r]) m_stable = 1'b0;
      m_prev = m_cur;
      m_cur  = nx;
      m_gen  = (m_gen + 1) % 65536;
   endtask

   // One clock with the given command; leaves the bench 1ns after the edge.
   task automatic cyc(input bit we, input int row, input logic [15:0] val, input bit st);
      write_enb = we;
      vali_selector = 4'(row);
      vali = val;
      step = st;
      @(posedge clk);
      if (we) begin
         m_cur[row] = val;
         m_stable = 1'b0;
      end else if (st) begin
         model_step();
      end
      #1;
      write_enb = 1'b0;
      step = 1'b0;
   endtask

   task automatic read_dut();
      for (int r = 0; r < R; r++) begin
         valo_selector = 4'(r);
         #1;
         dut_cur[r]  = valo;
         dut_prev[r] = valo_prev;
      end
   endtask

   task automatic apply_reset();
      #5 reset = 1'b1;
      #2 reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #5;
      read_dut();
      for (int r = 0; r < R; r++) begin
         n_checks++;
         if (dut_cur[r] !== 16'h0 || dut_prev[r] !== 16'h0)
            $display("FAIL reset_row%0d: got %h/%h expected 0000/0000", r, dut_cur[r], dut_prev[r]);
         else n_pass++;
      end
      n_checks++;
      if ({generation, stable, no, so, wo, eo, nwo, neo, seo, swo} !== '0)
         $display("FAIL reset_outputs: gen=%h stable=%b no=%h wo=%h expected all 0", generation, stable, no, wo);
      else n_pass++;
      #4 reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_blinker();
      logic [15:0] want;
      apply_reset();
      cyc(1, 7, 16'h01C0, 0);
      cyc(0, 0, 16'h0, 1);
      read_dut();
      for (int r = 0; r < R; r++) begin
         want = (r >= 6 && r <= 8) ? 16'h0080 : 16'h0000;
         n_checks++;
         if (dut_cur[r] !== want) $display("FAIL blinker1_row%0d: got %h expected %h", r, dut_cur[r], want);
         else n_pass++;
      end
      n_checks++;
      if (dut_prev[7] !== 16'h01C0) $display("FAIL blinker1_prev7: got %h expected 01c0", dut_prev[7]);
      else n_pass++;
      n_checks++;
      if (generation !== 16'd1 || stable !== 1'b0)
         $display("FAIL blinker1_gen: got gen=%0d stable=%b expected gen=1 stable=0", generation, stable);
      else n_pass++;
      cyc(0, 0, 16'h0, 1);
      read_dut();
      for (int r = 6; r <= 8; r++) begin
         want = (r == 7) ? 16'h01C0 : 16'h0000;
         n_checks++;
         if (dut_cur[r] !== want) $display("FAIL blinker2_row%0d: got %h expected %h", r, dut_cur[r], want);
         else n_pass++;
      end
      n_checks++;
      if (generation !== 16'd2) $display("FAIL blinker2_gen: got %0d expected 2", generation);
      else n_pass++;
   endtask

   task automatic test_block();
      logic [15:0] want;
      apply_reset();
      cyc(1, 4, 16'h0030, 0);
      cyc(1, 5, 16'h0030, 0);
      cyc(0, 0, 16'h0, 1);
      read_dut();
      for (int r = 0; r < R; r++) begin
         want = (r == 4 || r == 5) ? 16'h0030 : 16'h0000;
         n_checks++;
         if (dut_cur[r] !== want) $display("FAIL block_row%0d: got %h expected %h", r, dut_cur[r], want);
         else n_pass++;
      end
      n_checks++;
      if (stable !== 1'b1 || generation !== 16'd1)
         $display("FAIL block_stable: got stable=%b gen=%0d expected stable=1 gen=1", stable, generation);
      else n_pass++;
      cyc(1, 10, 16'h0000, 0);
      n_checks++;
      if (stable !== 1'b0 || generation !== 16'd1)
         $display("FAIL block_write_clears: got stable=%b gen=%0d expected stable=0 gen=1", stable, generation);
      else n_pass++;
   endtask

   task automatic test_edge_birth();
      logic [15:0] want;
      apply_reset();
      ni = 16'h0007;
      wrap_mode = 1'b0;
      cyc(0, 0, 16'h0, 1);
      read_dut();
      for (int r = 0; r < R; r++) begin
         want = (r == 0) ? 16'h0002 : 16'h0000;
         n_checks++;
         if (dut_cur[r] !== want) $display("FAIL edge_birth_row%0d: got %h expected %h", r, dut_cur[r], want);
         else n_pass++;
      end
      apply_reset();
      wrap_mode = 1'b1;
      cyc(0, 0, 16'h0, 1);
      valo_selector = 4'd0;
      #1;
      n_checks++;
      if (valo !== 16'h0000) $display("FAIL edge_ignored_wrap: got %h expected 0000", valo);
      else n_pass++;
      ni = '0;
      wrap_mode = 1'b0;
   endtask

   task automatic test_wrap();
      logic [15:0] want;
      apply_reset();
      wrap_mode = 1'b1;
      cyc(1, 0, 16'h8003, 0);
      cyc(0, 0, 16'h0, 1);
      read_dut();
      for (int r = 0; r < R; r++) begin
         want = (r == 15 || r <= 1) ? 16'h0001 : 16'h0000;
         n_checks++;
         if (dut_cur[r] !== want) $display("FAIL wrap_row%0d: got %h expected %h", r, dut_cur[r], want);
         else n_pass++;
      end
      n_checks++;
      if (wo !== 16'h8003 || eo !== 16'h0000) $display("FAIL wrap_wo: got wo=%h eo=%h expected 8003/0000", wo, eo);
      else n_pass++;
      n_checks++;
      if ({nwo, neo, seo, swo} !== 4'b1001)
         $display("FAIL wrap_corners: got %b expected 1001", {nwo, neo, seo, swo});
      else n_pass++;
      wrap_mode = 1'b0;
   endtask

   task automatic test_collision();
      apply_reset();
      cyc(1, 7, 16'h01C0, 0);
      cyc(1, 2, 16'h00FF, 1);
      read_dut();
      n_checks++;
      if (dut_cur[2] !== 16'h00FF || dut_cur[7] !== 16'h01C0 || dut_cur[6] !== 16'h0000)
         $display("FAIL collision_rows: got r2=%h r6=%h r7=%h expected 00ff/0000/01c0", dut_cur[2], dut_cur[6], dut_cur[7]);
      else n_pass++;
      n_checks++;
      if (generation !== 16'd0 || stable !== 1'b0)
         $display("FAIL collision_gen: got gen=%0d stable=%b expected 0/0", generation, stable);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      cyc(1, 7, 16'h01C0, 0);
      step = 1'b1;
      valo_selector = 4'd7;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (generation !== 16'(k) || valo !== ((k % 2) ? 16'h0080 : 16'h01C0))
            $display("FAIL b2b_step%0d: got gen=%0d row7=%h expected gen=%0d row7=%h",
                     k, generation, valo, k, (k % 2) ? 16'h0080 : 16'h01C0);
         else n_pass++;
      end
      step = 1'b0;
   endtask

   task automatic test_reset_midrun();
      apply_reset();
      cyc(1, 7, 16'h01C0, 0);
      for (int k = 0; k < 5; k++) cyc(0, 0, 16'h0, 1);
      valo_selector = 4'd7;
      #1;
      n_checks++;
      if (generation !== 16'd5 || valo !== 16'h0080 || valo_prev !== 16'h01C0)
         $display("FAIL midrun_before: got gen=%0d row7=%h prev7=%h expected 5/0080/01c0", generation, valo, valo_prev);
      else n_pass++;
      #5 reset = 1'b1;
      #2;
      n_checks++;
      if (valo !== 16'h0 || valo_prev !== 16'h0 || generation !== 16'd0 || stable !== 1'b0)
         $display("FAIL midrun_cleared: got row7=%h prev7=%h gen=%0d stable=%b expected all 0", valo, valo_prev, generation, stable);
      else n_pass++;
      #2 reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      ni = 16'h0007;
      cyc(0, 0, 16'h0, 1);
      read_dut();
      n_checks++;
      if (dut_cur[0] !== 16'h0002 || dut_cur[7] !== 16'h0000 || generation !== 16'd1)
         $display("FAIL midrun_after: got r0=%h r7=%h gen=%0d expected 0002/0000/1", dut_cur[0], dut_cur[7], generation);
      else n_pass++;
      ni = '0;
   endtask

   task automatic test_random();
      int op;
      logic [15:0] ewo, eeo;
      apply_reset();
      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 3);
         wrap_mode = 1'($urandom);
         ni = 16'($urandom); si = 16'($urandom);
         wi = 16'($urandom); ei = 16'($urandom);
         {nwi, nei, sei, swi} = 4'($urandom);
         cyc(op[0], $urandom_range(0, 15), 16'($urandom), op[1]);
         read_dut();
         for (int r = 0; r < R; r++) begin
            n_checks++;
            if (dut_cur[r] !== m_cur[r] || dut_prev[r] !== m_prev[r])
               $display("FAIL rand%0d_row%0d: got %h/%h expected %h/%h", it, r, dut_cur[r], dut_prev[r], m_cur[r], m_prev[r]);
            else n_pass++;
         end
         n_checks++;
         if (generation !== 16'(m_gen) || stable !== m_stable)
            $display("FAIL rand%0d_gen: got gen=%0d stable=%b expected %0d/%b", it, generation, stable, m_gen, m_stable);
         else n_pass++;
         for (int r = 0; r < R; r++) begin
            ewo[r] = m_cur[r][0];
            eeo[r] = m_cur[r][C-1];
         end
         n_checks++;
         if ({no, so, wo, eo, nwo, neo, seo, swo} !==
             {m_cur[0], m_cur[R-1], ewo, eeo, m_cur[0][0], m_cur[0][C-1], m_cur[R-1][C-1], m_cur[R-1][0]})
            $display("FAIL rand%0d_edges: got no=%h so=%h wo=%h eo=%h expected %h %h %h %h",
                     it, no, so, wo, eo, m_cur[0], m_cur[R-1], ewo, eeo);
         else n_pass++;
      end
      {ni, si, wi, ei} = '0;
      {nwi, nei, sei, swi} = '0;
      wrap_mode = 1'b0;
   endtask

   task automatic test_small();
      logic [5:0] want;
      apply_reset();
      for (int r = 1; r <= 7; r++) begin
         if (r == 4) continue;
         s_we = 1'b1;
         s_vsel = 3'(r);
         s_vali = (r <= 3) ? 6'b000100 : 6'b111111;
         @(posedge clk);
         #1;
      end
      s_we = 1'b0;
      for (int r = 0; r < 8; r++) begin
         s_osel = 3'(r);
         #1;
         want = (r >= 1 && r <= 3) ? 6'b000100 : 6'b000000;
         n_checks++;
         if (s_valo !== want) $display("FAIL small_sel%0d: got %h expected %h", r, s_valo, want);
         else n_pass++;
      end
      s_step = 1'b1;
      @(posedge clk);
      #1;
      s_step = 1'b0;
      s_osel = 3'd2;
      #1;
      n_checks++;
      if (s_valo !== 6'b001110 || s_gen !== 3'd1)
         $display("FAIL small_step: got row2=%h gen=%0d expected 0e/1", s_valo, s_gen);
      else n_pass++;
      s_osel = 3'd6;
      #1;
      n_checks++;
      if (s_valo !== 6'h0 || s_valo_prev !== 6'h0)
         $display("FAIL small_oob_read: got %h/%h expected 00/00", s_valo, s_valo_prev);
      else n_pass++;
      n_checks++;
      if ({s_no, s_so, s_wo, s_eo, s_nwo, s_neo, s_seo, s_swo, s_stable} !== '0)
         $display("FAIL small_edges: got no=%h so=%h wo=%h eo=%h expected 0", s_no, s_so, s_wo, s_eo);
      else n_pass++;
      s_step = 1'b1;
      for (int k = 2; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (k >= 8) begin
            n_checks++;
            if (s_gen !== 3'(k % 8)) $display("FAIL small_gen_wrap%0d: got %0d expected %0d", k, s_gen, k % 8);
            else n_pass++;
         end
      end
      s_step = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_blinker();
      test_block();
      test_edge_birth();
      test_wrap();
      test_collision();
      test_back_to_back();
      test_reset_midrun();
      test_random();
      test_small();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/life_array_param.md
Name: life_array_param

Overview:
- Parametrised Game-of-Life cell array; generalises the fixed 16x16 tiled array to any ROWS x COLS.
- Single flat cell store with row-wise load/readback, a previous-generation snapshot, and edge/corner ports for tiling into larger fabrics.
- Adds features the fixed array lacks:
  - selectable toroidal wrap mode;
  - generation counter;
  - stable-pattern detection;
  - defined write/step collision rules.
- Sits under the controller IP, which drives load, step and readback.

Parameters:
ROWS, 16, number of rows (>=3)
COLS, 16, number of columns (>=3); row width of vali/valo
SEL_W, $clog2(ROWS), row selector width
GEN_W, 16, generation counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all state
vali  in  COLS  row data to write; bit c = column c (c=0 is west)
vali_selector  in  SEL_W  row index for write
write_enb  in  1  write vali into row vali_selector this cycle
valo_selector  in  SEL_W  row index for readback
valo  out  COLS  current generation of row valo_selector (combinational)
valo_prev  out  COLS  previous generation of row valo_selector (combinational)
step  in  1  advance one generation this cycle
wrap_mode  in  1  1 = toroidal, 0 = neighbours beyond the edge come from the edge inputs
ni, si  in  COLS  neighbour row above row 0 / below row ROWS-1
wi, ei  in  ROWS  neighbour column west of col 0 / east of col COLS-1; bit r = row r
nwi, nei, sei, swi  in  1  diagonal corner neighbours
no, so  out  COLS  row 0 / row ROWS-1 of the current generation
wo, eo  out  ROWS  column 0 / column COLS-1 of the current generation; bit r = row r
nwo, neo, seo, swo  out  1  corner cells [0][0], [0][COLS-1], [ROWS-1][COLS-1], [ROWS-1][0]
generation  out  GEN_W  count of steps since reset
stable  out  1  last step produced no change

Behaviour:
- Reset (async): all cells 0, snapshot 0, generation 0, stable 0. Consequently all outputs are 0.
- Cell rule B3/S23, evaluated on all cells in parallel from the current state:
  - dead cell with exactly 3 live neighbours -> live;
  - live cell with 2 or 3 live neighbours -> stays live;
  - all other cells -> dead.
- Neighbours outside the array:
  - wrap_mode=0: taken from ni/si/wi/ei and the corner inputs.
  - wrap_mode=1: taken from the opposite edge. Edge and corner inputs are ignored.
  - wrap_mode is sampled on the step cycle.
- Step (step=1, write_enb=0) on edge k:
  - snapshot <= current; current <= next;
  - generation <= generation+1, wrapping from 2^GEN_W-1 to 0;
  - stable <= (next == current).
  - New values are visible on valo, edge outputs and valo_prev immediately after edge k; latency is 1 clock.
- Write (write_enb=1):
  - row vali_selector <= vali on the clock edge; snapshot and generation are unchanged; stable <= 0.
- write_enb and step in the same cycle: the write wins. No evolution, generation is not incremented, stable <= 0.
- Selector >= ROWS (non-power-of-2 ROWS): the write is ignored, and valo/valo_prev read 0.
- Consecutive steps on back-to-back cycles are legal; each cycle advances one generation.
- Edge and corner outputs always reflect the current generation. They are combinational from registers, with no path from the inputs.
- Reset asserted mid-run: state clears immediately. The first step after release uses the cleared array.

Test Plan:
- Blinker, 16x16, wrap=0, edge inputs 0: write row7=0x01C0, then step.
  - After step 1: rows 6, 7, 8 = 0x0080; valo_prev row7 = 0x01C0; generation=1; stable=0.
  - After step 2: row7=0x01C0, rows 6 and 8 = 0; generation=2.
- Block still life: write rows 4 and 5 = 0x0030, then step -> rows unchanged, stable=1, generation=1. A subsequent write clears stable to 0.
- Edge input birth, empty array: wrap=0, ni=0x0007, step -> row0=0x0002, all other rows 0. The same stimulus with wrap=1 -> row0 stays 0.
- Toroidal wrap: wrap=1, write row0=0x8003, step.
  - rows 15, 0, 1 = 0x0001.
  - wo bits 15, 0, 1 set; nwo=1; swo=1.
- Collision: with the blinker loaded, assert write_enb (row2=0x00FF) and step together -> row2=0x00FF, blinker not evolved, generation unchanged.
- Reset mid-run: after 5 steps, pulse reset asynchronously (between edges) -> valo=0, valo_prev=0, generation=0, stable=0 before the next clock edge.
